calc_entry_ctrl: RTL and testbench
==================================

# calc_entry_ctrl

Operand-entry and sequencing controller for the calculator. It turns four push-buttons into two 2-digit BCD operands and an operator. It starts the arithmetic unit with a one-cycle pulse, waits for its completion handshake or a timeout, then holds a result-display state. It sits between the board buttons and the arithmetic unit and display mux, and owns all user-entry state.

## Interface
- TIMEOUT, 1000: maximum cycles to wait for `alu_done` before flagging an error; counter width is clog2(TIMEOUT+1).

- clk  in  1  system clock; all flops on its rising edge
- rst  in  1  asynchronous, active-low reset; clears all state immediately
- btn_inc  in  1  raw button: increment digit under cursor
- btn_next  in  1  raw button: advance cursor
- btn_op  in  1  raw button: cycle operator
- btn_eq  in  1  raw button: evaluate / acknowledge result
- alu_done  in  1  arithmetic unit finished (level or pulse)
- a_bcd  out  8  operand A, {tens, ones}, each digit 0..9
- b_bcd  out  8  operand B, {tens, ones}, each digit 0..9
- op  out  2  operator: 0 add, 1 sub, 2 mul, 3 div
- cursor  out  2  active digit: 0 A.tens, 1 A.ones, 2 B.tens, 3 B.ones
- alu_start  out  1  one-cycle start pulse to arithmetic unit
- busy  out  1  high while in CALC
- show  out  1  high while in SHOW
- err  out  1  last evaluation timed out; valid while `show` is high

## Operation
- Each button passes through a 2-flop synchronizer plus one history flop. A rising edge produces one action; holding the button produces nothing further. The synchronizer and history flops reset to 0.
- States: ENTRY (reset state), CALC, SHOW.
- Same-cycle edge priority: eq > next > inc > op. Lower-priority edges in that cycle are discarded, not queued.
- ENTRY:
  - inc: the digit at `cursor` increments, wrapping 9 -> 0.
  - next: `cursor` advances 0 -> 1 -> 2 -> 3 -> 0.
  - op: `op` advances 0 -> 1 -> 2 -> 3 -> 0.
  - eq: go to CALC, pulse `alu_start`, clear the timeout counter and `err`.
- CALC:
  - `busy` = 1. All button edges are discarded.
  - `alu_done` is sampled only on cycles where `alu_start` = 0.
  - `alu_done` = 1: go to SHOW with `err` = 0.
  - Otherwise the counter increments each cycle. When it reaches TIMEOUT: go to SHOW with `err` = 1.
  - `alu_done` and timeout on the same cycle: `alu_done` wins and `err` = 0.
- SHOW:
  - `show` = 1.
  - eq: return to ENTRY with operands, op and cursor kept.
  - inc or next: return to ENTRY with both operands cleared to 0 and cursor = 0. `op` is kept, and the triggering edge is consumed without being applied.
  - op: discarded.
  - `err` holds until the next CALC entry.
- Operands, op and cursor never change outside the cases above. No illegal BCD value (A..F) is ever produced.

## Timing
- Reset (rst = 0), all outputs: a_bcd = 0, b_bcd = 0, op = 0, cursor = 0, alu_start = 0, busy = 0, show = 0, err = 0, state ENTRY. Reset takes effect immediately, including mid-CALC, where `alu_start` drops at once.
- Button latency: a button first sampled high at edge N updates its register at edge N+2.
- A button held high across reset release produces exactly one action.
- eq in ENTRY sampled at edge N:
  - edge N+2: state = CALC, `busy` = 1, `alu_start` = 1.
  - edge N+3: `alu_start` = 0.
- `alu_done` sampled high at edge M in CALC (M >= N+3): edge M: state = SHOW, `busy` = 0, `show` = 1.
- Timeout: the counter is 0 at edge N+2. If `alu_done` never arrives, the transition to SHOW with `err` = 1 happens at edge N+2+TIMEOUT.
- Exactly one `alu_start` pulse per evaluation.

## Test plan
- Reset, then 12 inc presses at cursor 0 -> a_bcd = 0x20 (tens digit wraps to 0 after 10 presses, then reaches 2). cursor stays 0; b_bcd = 0x00.
- next x2, then inc x3, then op x5 -> cursor = 2, b_bcd = 0x30, op = 1. A single 50-cycle button hold produces exactly one action.
- eq and inc edges in the same cycle -> only the eq action occurs (digit unchanged). `alu_start` is high for exactly 1 cycle. `alu_done` driven on the `alu_start` cycle is ignored; `alu_done` 5 cycles later gives `show` = 1, `err` = 0.
- With TIMEOUT = 8 and `alu_done` held low -> `show` = 1 and `err` = 1 exactly 8 cycles after `busy` rises. Presses during CALC change nothing.
- In SHOW, press next -> ENTRY with a_bcd = b_bcd = 0 and cursor = 0, op preserved. In SHOW, press eq -> ENTRY with operands preserved.
- Assert rst mid-CALC -> all outputs go to 0 without waiting for a clock edge. After release, `alu_done` = 1 causes no transition.

Source files
------------

// File: rtl/calc_entry_ctrl.sv
// Calculator operand-entry and sequencing controller.
// Buttons edit two BCD operands and an operator, then launch and await the ALU.
module calc_entry_ctrl #(
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_inc,
    input  logic       btn_next,
    input  logic       btn_op,
    input  logic       btn_eq,
    input  logic       alu_done,
    output logic [7:0] a_bcd,
    output logic [7:0] b_bcd,
    output logic [1:0] op,
    output logic [1:0] cursor,
    output logic       alu_start,
    output logic       busy,
    output logic       show,
    output logic       err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ENTRY,
        CALC,
        SHOW
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    btns;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    hist;
    logic [3:0]    rise;
    logic          act_eq;
    logic          act_next;
    logic          act_inc;
    logic          act_op;

    // Bit order {eq, next, inc, op} matches edge priority, highest first.
    assign btns = {btn_eq, btn_next, btn_inc, btn_op};
    assign rise = sync2 & ~hist;

    assign act_eq   = rise[3];
    assign act_next = rise[2] & ~rise[3];
    assign act_inc  = rise[1] & ~|rise[3:2];
    assign act_op   = rise[0] & ~|rise[3:1];

    function automatic logic [3:0] bump(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= btns;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ENTRY;
            cnt       <= '0;
            a_bcd     <= '0;
            b_bcd     <= '0;
            op        <= '0;
            cursor    <= '0;
            alu_start <= 1'b0;
            busy      <= 1'b0;
            show      <= 1'b0;
            err       <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            case (state)
                ENTRY: begin
                    unique case (1'b1)
                        act_eq: begin
                            state     <= CALC;
                            busy      <= 1'b1;
                            alu_start <= 1'b1;
                            cnt       <= '0;
                            err       <= 1'b0;
                        end
                        act_next: cursor <= cursor + 2'd1;
                        act_inc: begin
                            case (cursor)
                                2'd0: a_bcd[7:4] <= bump(a_bcd[7:4]);
                                2'd1: a_bcd[3:0] <= bump(a_bcd[3:0]);
                                2'd2: b_bcd[7:4] <= bump(b_bcd[7:4]);
                                default: b_bcd[3:0] <= bump(b_bcd[3:0]);
                            endcase
                        end
                        act_op: op <= op + 2'd1;
                        default: ;
                    endcase
                end
                CALC: begin
                    // The start cycle never counts as completion.
                    if (!alu_start && alu_done) begin
                        state <= SHOW;
                        busy  <= 1'b0;
                        show  <= 1'b1;
                        err   <= 1'b0;
                    end else if (cnt == LAST) begin
                        state <= SHOW;
                        busy  <= 1'b0;
                        show  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SHOW: begin
                    unique case (1'b1)
                        act_eq: begin
                            state <= ENTRY;
                            show  <= 1'b0;
                        end
                        act_next, act_inc: begin
                            state  <= ENTRY;
                            show   <= 1'b0;
                            a_bcd  <= '0;
                            b_bcd  <= '0;
                            cursor <= '0;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    state <= ENTRY;
                    busy  <= 1'b0;
                    show  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl with TIMEOUT = 8.
// Each task drives one scenario and checks hand-computed values inline.
module tb_calc_entry_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_inc;
    logic       btn_next;
    logic       btn_op;
    logic       btn_eq;
    logic       alu_done;
    logic [7:0] a_bcd;
    logic [7:0] b_bcd;
    logic [1:0] op;
    logic [1:0] cursor;
    logic       alu_start;
    logic       busy;
    logic       show;
    logic       err;

    int checks = 0;
    int errors = 0;
    int starts = 0;

    calc_entry_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk),
        .rst(rst),
        .btn_inc(btn_inc),
        .btn_next(btn_next),
        .btn_op(btn_op),
        .btn_eq(btn_eq),
        .alu_done(alu_done),
        .a_bcd(a_bcd),
        .b_bcd(b_bcd),
        .op(op),
        .cursor(cursor),
        .alu_start(alu_start),
        .busy(busy),
        .show(show),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (alu_start) starts++;

    // 0 inc, 1 next, 2 op, 3 eq
    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: btn_inc = v;
            1: btn_next = v;
            2: btn_op = v;
            default: btn_eq = v;
        endcase
    endtask

    task automatic press(input int idx);
        @(negedge clk);
        set_btn(idx, 1'b1);
        repeat (2) @(negedge clk);
        set_btn(idx, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        btn_inc = 1'b0;
        btn_next = 1'b0;
        btn_op = 1'b0;
        btn_eq = 1'b0;
        alu_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_bcd !== 8'h00) begin errors++; $display("FAIL reset a_bcd got %h exp 00", a_bcd); end
        checks++; if (b_bcd !== 8'h00) begin errors++; $display("FAIL reset b_bcd got %h exp 00", b_bcd); end
        checks++; if (op !== 2'd0) begin errors++; $display("FAIL reset op got %0d exp 0", op); end
        checks++; if (cursor !== 2'd0) begin errors++; $display("FAIL reset cursor got %0d exp 0", cursor); end
        checks++; if (alu_start !== 1'b0) begin errors++; $display("FAIL reset alu_start got %b exp 0", alu_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
        checks++; if (show !== 1'b0) begin errors++; $display("FAIL reset show got %b exp 0", show); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err got %b exp 0", err); end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_inc_wrap;
        for (int i = 0; i < 12; i++) press(0);
        checks++; if (a_bcd !== 8'h20) begin errors++; $display("FAIL inc_wrap a_bcd got %h exp 20", a_bcd); end
        checks++; if (cursor !== 2'd0) begin errors++; $display("FAIL inc_wrap cursor got %0d exp 0", cursor); end
        checks++; if (b_bcd !== 8'h00) begin errors++; $display("FAIL inc_wrap b_bcd got %h exp 00", b_bcd); end
    endtask

    task automatic test_next_op;
        press(1);
        press(1);
        for (int i = 0; i < 3; i++) press(0);
        for (int i = 0; i < 5; i++) press(2);
        checks++; if (cursor !== 2'd2) begin errors++; $display("FAIL next_op cursor got %0d exp 2", cursor); end
        checks++; if (b_bcd !== 8'h30) begin errors++; $display("FAIL next_op b_bcd got %h exp 30", b_bcd); end
        checks++; if (op !== 2'd1) begin errors++; $display("FAIL next_op op got %0d exp 1", op); end
        checks++; if (a_bcd !== 8'h20) begin errors++; $display("FAIL next_op a_bcd got %h exp 20", a_bcd); end
    endtask

    task automatic test_hold;
        @(negedge clk);
        btn_op = 1'b1;
        repeat (50) @(negedge clk);
        btn_op = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (op !== 2'd2) begin errors++; $display("FAIL hold op got %0d exp 2", op); end
        checks++; if (cursor !== 2'd2) begin errors++; $display("FAIL hold cursor got %0d exp 2", cursor); end
    endtask

    task automatic test_timeout;
        int s0;
        s0 = starts;
        alu_done = 1'b0;
        @(negedge clk);
        btn_eq = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        btn_eq = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout busy_rise got %b exp 1", busy); end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) btn_inc = 1'b1;
            if (k == 2) btn_next = 1'b1;
            if (k == 3) btn_inc = 1'b0;
            if (k == 4) btn_next = 1'b0;
            if (k == 7) begin
                checks++; if (show !== 1'b0) begin errors++; $display("FAIL timeout early_show got %b exp 0", show); end
            end
        end
        checks++; if (show !== 1'b1) begin errors++; $display("FAIL timeout show got %b exp 1", show); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout err got %b exp 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout busy got %b exp 0", busy); end
        checks++; if (a_bcd !== 8'h20 || b_bcd !== 8'h30) begin errors++; $display("FAIL timeout operands got %h %h exp 20 30", a_bcd, b_bcd); end
        checks++; if (cursor !== 2'd2) begin errors++; $display("FAIL timeout cursor got %0d exp 2", cursor); end
        checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL timeout starts got %0d exp 1", starts - s0); end
    endtask

    task automatic test_show_eq;
        press(3);
        checks++; if (show !== 1'b0) begin errors++; $display("FAIL show_eq show got %b exp 0", show); end
        checks++; if (a_bcd !== 8'h20 || b_bcd !== 8'h30) begin errors++; $display("FAIL show_eq operands got %h %h exp 20 30", a_bcd, b_bcd); end
        checks++; if (cursor !== 2'd2 || op !== 2'd2) begin errors++; $display("FAIL show_eq cursor/op got %0d %0d exp 2 2", cursor, op); end
    endtask

    task automatic test_eq_priority;
        int s0;
        s0 = starts;
        @(negedge clk);
        btn_eq = 1'b1;
        btn_inc = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        btn_eq = 1'b0;
        btn_inc = 1'b0;
        checks++; if (alu_start !== 1'b0) begin errors++; $display("FAIL eq_prio early_start got %b exp 0", alu_start); end
        @(posedge clk); #1;
        checks++; if (alu_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL eq_prio start/busy got %b %b exp 1 1", alu_start, busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL eq_prio err_clear got %b exp 0", err); end
        alu_done = 1'b1;
        @(posedge clk); #1;
        alu_done = 1'b0;
        checks++; if (alu_start !== 1'b0) begin errors++; $display("FAIL eq_prio start_drop got %b exp 0", alu_start); end
        checks++; if (show !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL eq_prio done_ignored show/busy got %b %b exp 0 1", show, busy); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (show !== 1'b0) begin errors++; $display("FAIL eq_prio wait_show got %b exp 0", show); end
        alu_done = 1'b1;
        @(posedge clk); #1;
        alu_done = 1'b0;
        checks++; if (show !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL eq_prio done show/err/busy got %b %b %b exp 1 0 0", show, err, busy); end
        checks++; if (b_bcd !== 8'h30) begin errors++; $display("FAIL eq_prio b_bcd got %h exp 30", b_bcd); end
        checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL eq_prio starts got %0d exp 1", starts - s0); end
    endtask

    task automatic test_show_next;
        press(1);
        checks++; if (show !== 1'b0) begin errors++; $display("FAIL show_next show got %b exp 0", show); end
        checks++; if (a_bcd !== 8'h00 || b_bcd !== 8'h00) begin errors++; $display("FAIL show_next operands got %h %h exp 00 00", a_bcd, b_bcd); end
        checks++; if (cursor !== 2'd0) begin errors++; $display("FAIL show_next cursor got %0d exp 0", cursor); end
        checks++; if (op !== 2'd2) begin errors++; $display("FAIL show_next op got %0d exp 2", op); end
    endtask

    task automatic test_reset_mid_calc;
        press(0);
        checks++; if (a_bcd !== 8'h10) begin errors++; $display("FAIL mid_rst pre a_bcd got %h exp 10", a_bcd); end
        @(negedge clk);
        btn_eq = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        btn_eq = 1'b0;
        @(posedge clk); #1;
        checks++; if (alu_start !== 1'b1) begin errors++; $display("FAIL mid_rst start got %b exp 1", alu_start); end
        #2;
        rst = 1'b0;
        btn_inc = 1'b1;
        #1;
        checks++; if (alu_start !== 1'b0 || busy !== 1'b0 || show !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_rst flags got %b %b %b %b exp 0 0 0 0", alu_start, busy, show, err); end
        checks++; if (a_bcd !== 8'h00 || op !== 2'd0 || cursor !== 2'd0) begin errors++; $display("FAIL mid_rst regs got %h %0d %0d exp 00 0 0", a_bcd, op, cursor); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        alu_done = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b0 || show !== 1'b0) begin errors++; $display("FAIL mid_rst done_ignored busy/show got %b %b exp 0 0", busy, show); end
        checks++; if (a_bcd !== 8'h10) begin errors++; $display("FAIL mid_rst held_inc a_bcd got %h exp 10", a_bcd); end
        repeat (40) @(negedge clk);
        btn_inc = 1'b0;
        alu_done = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (a_bcd !== 8'h10) begin errors++; $display("FAIL mid_rst held_once a_bcd got %h exp 10", a_bcd); end
    endtask

    initial begin
        test_reset;
        test_inc_wrap;
        test_next_op;
        test_hold;
        test_timeout;
        test_show_eq;
        test_eq_priority;
        test_show_next;
        test_reset_mid_calc;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
